vproc_div_wb: RTL and testbench

Result collector and vector-register writeback stage for the vector divide unit. Accepts DIV_OP_W-wide result beats with per-byte masks from the divider's output handshake, packs consecutive beats into VREG_W-wide register-file writes with byte enables, and issues them over a valid/ready write port. Sits between the divide pipeline output and the vector register file write arbiter.

---
 rtl/vproc_pkg.sv | 13 +
 rtl/vproc_div_wb_if.sv | 33 +++
 rtl/vproc_div_wb_buf.sv | 97 +++++++++
 rtl/vproc_div_wb.sv | 129 ++++++++++++
 tb/tb_vproc_div_wb.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/vproc_pkg.sv
// Shared vector-processor types: control struct carried alongside
// divide-unit result beats.
package vproc_pkg;

  localparam int VREG_ADDR_W = 5;

  typedef struct packed {
    logic                   first_cycle;
    logic                   last_cycle;
    logic [VREG_ADDR_W-1:0] res_vaddr;
  } div_ctrl_t;

endpackage

// File: rtl/vproc_div_wb_if.sv
// Divider-result input handshake and vector-register write port of the
// divide writeback stage; slave is the writeback block, master its environment.
interface vproc_div_wb_if #(
  parameter int  DIV_OP_W = 64,
  parameter int  VREG_W   = 128,
  parameter type CTRL_T   = vproc_pkg::div_ctrl_t
);
  logic                  pipe_in_valid_i;
  logic                  pipe_in_ready_o;
  CTRL_T                 pipe_in_ctrl_i;
  logic [DIV_OP_W-1:0]   pipe_in_res_i;
  logic [DIV_OP_W/8-1:0] pipe_in_mask_i;
  logic                  vreg_wr_valid_o;
  logic                  vreg_wr_ready_i;
  logic [4:0]            vreg_wr_addr_o;
  logic [VREG_W-1:0]     vreg_wr_data_o;
  logic [VREG_W/8-1:0]   vreg_wr_be_o;
  logic                  vreg_wr_last_o;

  modport slave (
    input  pipe_in_valid_i, pipe_in_ctrl_i, pipe_in_res_i, pipe_in_mask_i,
           vreg_wr_ready_i,
    output pipe_in_ready_o, vreg_wr_valid_o, vreg_wr_addr_o, vreg_wr_data_o,
           vreg_wr_be_o, vreg_wr_last_o
  );

  modport master (
    output pipe_in_valid_i, pipe_in_ctrl_i, pipe_in_res_i, pipe_in_mask_i,
           vreg_wr_ready_i,
    input  pipe_in_ready_o, vreg_wr_valid_o, vreg_wr_addr_o, vreg_wr_data_o,
           vreg_wr_be_o, vreg_wr_last_o
  );
endinterface

// File: rtl/vproc_div_wb_buf.sv
// One collection bank: packs result beats into a register-wide word with byte
// enables, tracks its destination address, last flag and slot counter.
module vproc_div_wb_buf #(
  parameter int DIV_OP_W = 64,
  parameter int VREG_W   = 128
) (
  input  logic                  clk_i,
  input  logic                  sync_rst_ni,
  input  logic                  beat_i,
  input  logic                  first_i,
  input  logic                  last_i,
  input  logic [4:0]            vaddr_i,
  input  logic [DIV_OP_W-1:0]   res_i,
  input  logic [DIV_OP_W/8-1:0] mask_i,
  input  logic                  commit_i,
  output logic                  full_o,
  output logic [4:0]            beat_addr_o,
  output logic [VREG_W-1:0]     data_o,
  output logic [VREG_W/8-1:0]   be_o,
  output logic [4:0]            addr_o,
  output logic                  last_o
);
  localparam int SLOTS  = VREG_W / DIV_OP_W;
  localparam int CNT_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int MASK_W = DIV_OP_W / 8;

  logic [VREG_W-1:0] data_q, data_d;
  logic [VREG_W/8-1:0] be_q, be_d;
  logic [4:0]        addr_q, addr_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_eff;

  function automatic logic [DIV_OP_W-1:0] mask_bytes(input logic [DIV_OP_W-1:0] res,
                                                     input logic [MASK_W-1:0]   mask);
    logic [DIV_OP_W-1:0] r;
    for (int b = 0; b < MASK_W; b++) r[8*b +: 8] = res[8*b +: 8] & {8{mask[b]}};
    return r;
  endfunction

  always_comb begin
    data_d  = data_q;
    be_d    = be_q;
    addr_d  = addr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    // A first beat restarts the register regardless of leftover slot state.
    cnt_eff     = first_i ? '0 : cnt_q;
    beat_addr_o = (first_i || cnt_q == '0) ? vaddr_i : addr_q;
    full_o      = beat_i && (last_i || cnt_eff == CNT_W'(SLOTS - 1));

    if (commit_i) begin
      data_d = '0;
      be_d   = '0;
      cnt_d  = '0;
      if (!last_q) addr_d = addr_q + 5'd1;
    end

    if (beat_i) begin
      if (first_i) begin
        data_d = '0;
        be_d   = '0;
      end
      addr_d = beat_addr_o;
      for (int s = 0; s < SLOTS; s++) begin
        if (cnt_eff == CNT_W'(s)) begin
          data_d[s*DIV_OP_W +: DIV_OP_W] = mask_bytes(res_i, mask_i);
          be_d[s*MASK_W +: MASK_W]       = mask_i;
        end
      end
      last_d = last_i;
      cnt_d  = full_o ? '0 : cnt_eff + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      data_q <= '0;
      be_q   <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      be_q   <= be_d;
      addr_q <= addr_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign be_o   = be_q;
  assign addr_o = addr_q;
  assign last_o = last_q;

endmodule

// File: rtl/vproc_div_wb.sv
// Vector divide writeback: collects result beats into register-wide writes.
// Define VPROC_DIV_WB_DBUF_EN for two ping-pong banks (fill one while flushing the other).
module vproc_div_wb
  import vproc_pkg::*;
#(
  parameter int  DIV_OP_W = 64,
  parameter int  VREG_W   = 128,
  parameter type CTRL_T   = div_ctrl_t
) (
  input logic           clk_i,
  input logic           sync_rst_ni,
  vproc_div_wb_if.slave bus
);
`ifdef VPROC_DIV_WB_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic DBUF = (NB == 2);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_e;

  state_e     state_q [NB];
  state_e     state_d [NB];
  logic       fill_sel_q, fill_sel_d;
  logic       wr_sel_q, wr_sel_d;
  logic [4:0] next_addr_q, next_addr_d;

  CTRL_T      ctrl;
  logic [4:0] vaddr;
  logic       rdy, acc, wr_hs, any_full;
  logic       wr_valid, wr_last;
  logic [4:0] wr_addr;
  logic [VREG_W-1:0]   wr_data;
  logic [VREG_W/8-1:0] wr_be;

  logic [NB-1:0]       beat, commit, full, bank_last;
  logic [4:0]          beat_addr [NB];
  logic [4:0]          bank_addr [NB];
  logic [VREG_W-1:0]   bank_data [NB];
  logic [VREG_W/8-1:0] bank_be   [NB];

  assign ctrl  = bus.pipe_in_ctrl_i;
  assign vaddr = ctrl.first_cycle ? ctrl.res_vaddr : next_addr_q;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    vproc_div_wb_buf #(.DIV_OP_W(DIV_OP_W), .VREG_W(VREG_W)) u_buf (
      .clk_i       (clk_i),
      .sync_rst_ni (sync_rst_ni),
      .beat_i      (beat[b]),
      .first_i     (ctrl.first_cycle),
      .last_i      (ctrl.last_cycle),
      .vaddr_i     (vaddr),
      .res_i       (bus.pipe_in_res_i),
      .mask_i      (bus.pipe_in_mask_i),
      .commit_i    (commit[b]),
      .full_o      (full[b]),
      .beat_addr_o (beat_addr[b]),
      .data_o      (bank_data[b]),
      .be_o        (bank_be[b]),
      .addr_o      (bank_addr[b]),
      .last_o      (bank_last[b])
    );
  end

  // Handshakes: the fill bank takes beats unless pending; the oldest pending bank drives the write port.
  always_comb begin
    rdy      = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_be    = '0;
    wr_last  = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (fill_sel_q == 1'(b)) rdy = (state_q[b] != FLUSH);
      if (wr_sel_q == 1'(b)) begin
        wr_valid = (state_q[b] == FLUSH);
        wr_addr  = bank_addr[b];
        wr_data  = bank_data[b];
        wr_be    = bank_be[b];
        wr_last  = bank_last[b];
      end
    end
    acc   = bus.pipe_in_valid_i && rdy;
    wr_hs = wr_valid && bus.vreg_wr_ready_i;
    for (int b = 0; b < NB; b++) begin
      beat[b]   = acc && (fill_sel_q == 1'(b));
      commit[b] = wr_hs && (wr_sel_q == 1'(b));
    end
  end

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    any_full    = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (commit[b]) state_d[b] = bank_last[b] ? IDLE : FILL;
      if (beat[b])   state_d[b] = full[b] ? FLUSH : FILL;
      if (full[b]) begin
        any_full    = 1'b1;
        next_addr_d = beat_addr[b] + 5'd1;
      end
    end
    fill_sel_d = fill_sel_q ^ (any_full & DBUF);
    wr_sel_d   = wr_sel_q ^ (wr_hs & DBUF);
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      for (int b = 0; b < NB; b++) state_q[b] <= IDLE;
      fill_sel_q  <= 1'b0;
      wr_sel_q    <= 1'b0;
      next_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_sel_q  <= fill_sel_d;
      wr_sel_q    <= wr_sel_d;
      next_addr_q <= next_addr_d;
    end
  end

  assign bus.pipe_in_ready_o = rdy;
  assign bus.vreg_wr_valid_o = wr_valid;
  assign bus.vreg_wr_addr_o  = wr_addr;
  assign bus.vreg_wr_data_o  = wr_data;
  assign bus.vreg_wr_be_o    = wr_be;
  assign bus.vreg_wr_last_o  = wr_last;

endmodule

// File: tb/tb_vproc_div_wb.sv
// Directed bench for vproc_div_wb (DIV_OP_W=64, VREG_W=128); the double-buffer
// scenario is built in when VPROC_DIV_WB_DBUF_EN is defined.
module tb_vproc_div_wb;
  import vproc_pkg::*;

`ifdef VPROC_DIV_WB_DBUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  vproc_div_wb_if #(.DIV_OP_W(64), .VREG_W(128)) bus ();

  vproc_div_wb #(.DIV_OP_W(64), .VREG_W(128)) dut (
    .clk_i       (clk),
    .sync_rst_ni (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] res, input logic [7:0] mask,
                      input logic first, input logic last, input logic [4:0] va);
    div_ctrl_t c;
    c.first_cycle          = first;
    c.last_cycle           = last;
    c.res_vaddr            = va;
    bus.pipe_in_valid_i    = 1'b1;
    bus.pipe_in_ctrl_i     = c;
    bus.pipe_in_res_i      = res;
    bus.pipe_in_mask_i     = mask;
  endtask

  task automatic idle();
    bus.pipe_in_valid_i = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 128'(bus.pipe_in_ready_o), 128'd1);
    chk({tag, "_valid"}, 128'(bus.vreg_wr_valid_o), 128'd0);
    chk({tag, "_addr"},  128'(bus.vreg_wr_addr_o),  128'd0);
    chk({tag, "_data"},  bus.vreg_wr_data_o,         128'd0);
    chk({tag, "_be"},    128'(bus.vreg_wr_be_o),     128'd0);
    chk({tag, "_last"},  128'(bus.vreg_wr_last_o),   128'd0);
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.pipe_in_valid_i  = 1'b0;
    bus.pipe_in_ctrl_i   = '0;
    bus.pipe_in_res_i    = '0;
    bus.pipe_in_mask_i   = '0;
    bus.vreg_wr_ready_i  = 1'b1;
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Full register: two beats, write one cycle after the completing beat.
    beat(64'h1111111111111111, 8'hFF, 1'b1, 1'b0, 5'd5);
    tick();
    chk("full_b0_valid", 128'(bus.vreg_wr_valid_o), 128'd0);
    chk("full_b0_ready", 128'(bus.pipe_in_ready_o), 128'd1);
    beat(64'h2222222222222222, 8'hFF, 1'b0, 1'b1, 5'd0);
    tick();
    idle();
    chk("full_valid", 128'(bus.vreg_wr_valid_o), 128'd1);
    chk("full_addr",  128'(bus.vreg_wr_addr_o),  128'd5);
    chk("full_data",  bus.vreg_wr_data_o, {64'h2222222222222222, 64'h1111111111111111});
    chk("full_be",    128'(bus.vreg_wr_be_o),    128'hFFFF);
    chk("full_last",  128'(bus.vreg_wr_last_o),  128'd1);
    chk("full_ready", 128'(bus.pipe_in_ready_o), 128'(DBUF));
    tick();
    chk("full_done_valid", 128'(bus.vreg_wr_valid_o), 128'd0);

    // Address wrap 31 -> 0 and a partial second register.
    beat(64'h3333333333333333, 8'hFF, 1'b1, 1'b0, 5'd31);
    tick();
    beat(64'h4444444444444444, 8'hFF, 1'b0, 1'b0, 5'd0);
    tick();
    beat(64'h5555555555555555, 8'hFF, 1'b0, 1'b1, 5'd0);
    chk("wrap_w0_valid", 128'(bus.vreg_wr_valid_o), 128'd1);
    chk("wrap_w0_addr",  128'(bus.vreg_wr_addr_o),  128'd31);
    chk("wrap_w0_be",    128'(bus.vreg_wr_be_o),    128'hFFFF);
    chk("wrap_w0_data",  bus.vreg_wr_data_o, {64'h4444444444444444, 64'h3333333333333333});
    chk("wrap_w0_last",  128'(bus.vreg_wr_last_o),  128'd0);
    tick();
`ifndef VPROC_DIV_WB_DBUF_EN
    chk("wrap_bubble_valid", 128'(bus.vreg_wr_valid_o), 128'd0);
    chk("wrap_bubble_ready", 128'(bus.pipe_in_ready_o), 128'd1);
    tick();
`endif
    idle();
    chk("wrap_w1_valid", 128'(bus.vreg_wr_valid_o), 128'd1);
    chk("wrap_w1_addr",  128'(bus.vreg_wr_addr_o),  128'd0);
    chk("wrap_w1_be",    128'(bus.vreg_wr_be_o),    128'h00FF);
    chk("wrap_w1_data",  bus.vreg_wr_data_o, {64'h0, 64'h5555555555555555});
    chk("wrap_w1_last",  128'(bus.vreg_wr_last_o),  128'd1);
    tick();
    chk("wrap_done_valid", 128'(bus.vreg_wr_valid_o), 128'd0);

    // Byte masking combined with write-port backpressure.
    beat(64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b1, 1'b0, 5'd7);
    tick();
    bus.vreg_wr_ready_i = 1'b0;
    beat(64'hBBBBBBBBBBBBBBBB, 8'hF0, 1'b0, 1'b1, 5'd0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("mask_valid", 128'(bus.vreg_wr_valid_o), 128'd1);
      chk("mask_addr",  128'(bus.vreg_wr_addr_o),  128'd7);
      chk("mask_be",    128'(bus.vreg_wr_be_o),    128'hF00F);
      chk("mask_data",  bus.vreg_wr_data_o, 128'hBBBBBBBB00000000_00000000AAAAAAAA);
      chk("mask_ready", 128'(bus.pipe_in_ready_o), 128'(DBUF));
      if (i < 3) tick();
    end
    bus.vreg_wr_ready_i = 1'b1;
    tick();
    chk("mask_done_valid", 128'(bus.vreg_wr_valid_o), 128'd0);

    // Reset after the first beat discards the partial register.
    beat(64'h6666666666666666, 8'hFF, 1'b1, 1'b0, 5'd9);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_vals("midrst");
    tick();
    tick();
    chk("midrst_no_write", 128'(bus.vreg_wr_valid_o), 128'd0);
    beat(64'h7777777777777777, 8'hFF, 1'b1, 1'b0, 5'd3);
    tick();
    beat(64'h8888888888888888, 8'hFF, 1'b0, 1'b1, 5'd0);
    tick();
    idle();
    chk("restart_valid", 128'(bus.vreg_wr_valid_o), 128'd1);
    chk("restart_addr",  128'(bus.vreg_wr_addr_o),  128'd3);
    chk("restart_data",  bus.vreg_wr_data_o, {64'h8888888888888888, 64'h7777777777777777});
    chk("restart_be",    128'(bus.vreg_wr_be_o),    128'hFFFF);
    chk("restart_last",  128'(bus.vreg_wr_last_o),  128'd1);
    tick();
    chk("restart_done_valid", 128'(bus.vreg_wr_valid_o), 128'd0);

`ifdef VPROC_DIV_WB_DBUF_EN
    // Ping-pong: four back-to-back beats while the write port stalls.
    bus.vreg_wr_ready_i = 1'b0;
    beat(64'hC0C0C0C0C0C0C0C0, 8'hFF, 1'b1, 1'b0, 5'd10);
    tick();
    chk("dbuf_b0_ready", 128'(bus.pipe_in_ready_o), 128'd1);
    beat(64'hD0D0D0D0D0D0D0D0, 8'hFF, 1'b0, 1'b0, 5'd0);
    tick();
    chk("dbuf_b1_valid", 128'(bus.vreg_wr_valid_o), 128'd1);
    chk("dbuf_b1_addr",  128'(bus.vreg_wr_addr_o),  128'd10);
    chk("dbuf_b1_ready", 128'(bus.pipe_in_ready_o), 128'd1);
    beat(64'hE0E0E0E0E0E0E0E0, 8'hFF, 1'b0, 1'b0, 5'd0);
    tick();
    chk("dbuf_b2_ready", 128'(bus.pipe_in_ready_o), 128'd1);
    beat(64'hF0F0F0F0F0F0F0F0, 8'hFF, 1'b0, 1'b1, 5'd0);
    tick();
    idle();
    chk("dbuf_both_ready", 128'(bus.pipe_in_ready_o), 128'd0);
    chk("dbuf_w0_valid",   128'(bus.vreg_wr_valid_o), 128'd1);
    chk("dbuf_w0_addr",    128'(bus.vreg_wr_addr_o),  128'd10);
    chk("dbuf_w0_data",    bus.vreg_wr_data_o, {64'hD0D0D0D0D0D0D0D0, 64'hC0C0C0C0C0C0C0C0});
    chk("dbuf_w0_last",    128'(bus.vreg_wr_last_o),  128'd0);
    bus.vreg_wr_ready_i = 1'b1;
    tick();
    chk("dbuf_w1_valid", 128'(bus.vreg_wr_valid_o), 128'd1);
    chk("dbuf_w1_addr",  128'(bus.vreg_wr_addr_o),  128'd11);
    chk("dbuf_w1_data",  bus.vreg_wr_data_o, {64'hF0F0F0F0F0F0F0F0, 64'hE0E0E0E0E0E0E0E0});
    chk("dbuf_w1_be",    128'(bus.vreg_wr_be_o),    128'hFFFF);
    chk("dbuf_w1_last",  128'(bus.vreg_wr_last_o),  128'd1);
    chk("dbuf_w1_ready", 128'(bus.pipe_in_ready_o), 128'd1);
    tick();
    chk("dbuf_done_valid", 128'(bus.vreg_wr_valid_o), 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
